// File: rtl/jpeg_stream_tx.sv
// JPEG byte stream sender: a runtime-length header fetched from a ROM, then the
// entropy-coded scan with 0xFF byte stuffing, RSTn markers and a closing EOI.
// All byte transfers use valid/ready handshakes.
module jpeg_stream_tx #(
  parameter int MAX_HDR_BYTES = 1024,
  parameter int HDR_AW        = $clog2(MAX_HDR_BYTES)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic [HDR_AW:0]   i_hdr_len,
  output logic [HDR_AW-1:0] o_hdr_addr,
  input  logic [7:0]        i_hdr_data,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  input  logic              i_restart,
  input  logic              i_last,
  output logic              o_ready,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_STUFF, S_RST0, S_RST1, S_EOI0, S_EOI1
  } state_t;

  state_t state, state_d;

  logic [HDR_AW:0] hdr_len;    // latched header length
  logic [HDR_AW:0] iss_cnt;    // ROM reads issued
  logic [HDR_AW:0] out_cnt;    // header bytes loaded into the output register
  logic            rd_pend;    // a ROM read was issued last cycle, data is on i_hdr_data
  logic            buf_vld;    // prefetch buffer holds a header byte
  logic [7:0]      buf_data;
  logic            pend_last;  // sideband of the most recently accepted scan byte
  logic            pend_rst;
  logic [2:0]      rst_cnt;

  logic       load_ok, xfer, accept;
  logic       hdr_have, hdr_take, hdr_issue;
  logic       ld, ld_last, rst_inc, busy_clr;
  logic [7:0] ld_data;

  // The output register can take a new byte when empty or draining this cycle.
  assign load_ok = !o_valid | i_ready;
  assign xfer    = o_valid & i_ready;
  assign o_ready = (state == S_DATA) & load_ok;
  assign accept  = o_ready & i_valid;

  // At most one header byte is ever in flight or buffered, so a read is only
  // issued when nothing will be left over after this cycle's load.
  assign hdr_have  = buf_vld | rd_pend;
  assign hdr_take  = (state == S_HDR) & hdr_have & load_ok;
  assign hdr_issue = (state == S_HDR) & (iss_cnt < hdr_len) & !(hdr_have & !hdr_take);

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and the byte to load into the output register.
  always_comb begin
    state_d  = state;
    ld       = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    rst_inc  = 1'b0;
    busy_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_d = (i_hdr_len != '0) ? S_HDR : S_DATA;
      end
      S_HDR: begin
        if (hdr_take) begin
          ld      = 1'b1;
          ld_data = buf_vld ? buf_data : i_hdr_data;
        end
        if (out_cnt == hdr_len && xfer) state_d = S_DATA;
      end
      S_DATA: begin
        if (accept) begin
          ld      = 1'b1;
          ld_data = i_data;
          if (i_data == 8'hFF) state_d = S_STUFF;
          else if (i_last)     state_d = S_EOI0;
          else if (i_restart)  state_d = S_RST0;
        end
      end
      S_STUFF: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = 8'h00;
          if (pend_last)     state_d = S_EOI0;
          else if (pend_rst) state_d = S_RST0;
          else               state_d = S_DATA;
        end
      end
      S_RST0: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = 8'hFF;
          state_d = S_RST1;
        end
      end
      S_RST1: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = {5'b11010, rst_cnt};
          rst_inc = 1'b1;
          state_d = S_DATA;
        end
      end
      S_EOI0: begin
        if (load_ok) begin
          ld      = 1'b1;
          ld_data = 8'hFF;
          state_d = S_EOI1;
        end
      end
      S_EOI1: begin
        // D9 sits in the output register flagged by o_last; finish on its transfer.
        if (o_valid && o_last) begin
          if (i_ready) begin
            busy_clr = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (load_ok) begin
          ld      = 1'b1;
          ld_data = 8'hD9;
          ld_last = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: holds while stalled, empties when drained with nothing new.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (ld) begin
      o_data  <= ld_data;
      o_valid <= 1'b1;
      o_last  <= ld_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

  // Header fetch, scan sideband capture, restart counter and busy flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hdr_len    <= '0;
      iss_cnt    <= '0;
      out_cnt    <= '0;
      o_hdr_addr <= '0;
      rd_pend    <= 1'b0;
      buf_vld    <= 1'b0;
      buf_data   <= 8'h00;
      pend_last  <= 1'b0;
      pend_rst   <= 1'b0;
      rst_cnt    <= 3'd0;
      o_busy     <= 1'b0;
    end else begin
      rd_pend <= hdr_issue;
      if (state == S_IDLE && i_start) begin
        hdr_len    <= i_hdr_len;
        iss_cnt    <= '0;
        out_cnt    <= '0;
        o_hdr_addr <= '0;
        buf_vld    <= 1'b0;
        rst_cnt    <= 3'd0;
        o_busy     <= 1'b1;
      end
      if (hdr_issue) begin
        o_hdr_addr <= o_hdr_addr + 1'b1;
        iss_cnt    <= iss_cnt + 1'b1;
      end
      if (hdr_take) begin
        buf_vld <= 1'b0;
        out_cnt <= out_cnt + 1'b1;
      end else if (rd_pend) begin
        buf_vld  <= 1'b1;
        buf_data <= i_hdr_data;
      end
      if (accept) begin
        pend_last <= i_last;
        pend_rst  <= i_restart;
      end
      if (rst_inc)  rst_cnt <= rst_cnt + 1'b1;
      if (busy_clr) o_busy  <= 1'b0;
    end
  end

endmodule
